nes_joypad: RTL and testbench
=============================

# nes_joypad

Standard NES controller emulator: the responder end of the serial joypad protocol driven by `cpu_memory` (`ctlr_latch`, `ctlr_pulse_pN`, `ctlr_data_pN`). It synchronizes and debounces eight raw board buttons, applies turbo and opposing-direction filtering, and captures the result on latch. It then shifts the buttons out one bit per read pulse, replacing the constant `ctlr_data_pN = 1` tie-off. One instance serves one controller port; player 1 and player 2 each get an instance.

## Interface
- `DEBOUNCE_CYCLES`, default 21477: consecutive stable cycles required to accept a button change (1 ms at master clock).
- `TURBO_HALF`, default 715909: cycles per turbo phase (15 Hz turbo).
- `BLOCK_OPPOSING`, default 1: 1 = report neither Up/Down (or Left/Right) when both are pressed.
- `clock  in  1`: master clock. One clock domain.
- `reset  in  1`: synchronous, active-high reset.
- `btn_raw  in  8`: asynchronous raw buttons, 1 = pressed. Bit order: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- `turbo_en  in  2`: synchronous config; bit0 = turbo A, bit1 = turbo B.
- `ctlr_latch  in  1`: strobe from `cpu_memory` ($4016 bit0 write), synchronous.
- `ctlr_pulse  in  1`: read clock from `cpu_memory`, high during a $4016/$4017 read, synchronous.
- `ctlr_data  out  1`: serial data, active-low (0 = pressed, 1 = released).
- `btn_state  out  8`: reported button state after debounce, turbo and opposing filter.
- `shift_count  out  4`: bits shifted since last latch, saturates at 8.

## Operation
- Synchronizer: two flops per `btn_raw` bit, producing `sync[7:0]`.
- Debounce, per bit: counter `cnt` of width clog2(DEBOUNCE_CYCLES+1) and stable bit `deb`.
  - `sync == deb`: `cnt <= 0`.
  - Otherwise `cnt` increments. When `cnt == DEBOUNCE_CYCLES-1` and the bit still differs, `deb <= sync` and `cnt <= 0`.
  - Any cycle where `sync` returns to `deb` clears `cnt`, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Turbo: free-running counter 0..TURBO_HALF-1. On wrap, `phase` toggles. Phase is 0 after reset.
  - `rep[0] = deb[0] & (turbo_en[0] ? phase : 1)`; same for bit1 with `turbo_en[1]`.
- Opposing filter (BLOCK_OPPOSING=1): if `deb[4]&deb[5]`, then `rep[5:4]=0`; if `deb[6]&deb[7]`, then `rep[7:6]=0`. Other bits pass through.
- `btn_state = rep`, combinational from registered state.
- Shift register `shreg[7:0]` and `count[3:0]`:
  - `ctlr_latch==1`: `shreg <= btn_state`, `count <= 0` every cycle (transparent reload).
  - Else, on a falling edge of `ctlr_pulse` (`pulse_q & ~ctlr_pulse`): `shreg <= {1'b0, shreg[7:1]}`, `count <= min(count+1, 8)`.
  - Shifting on the falling edge keeps `ctlr_data` stable throughout the read.
- `ctlr_data = (count < 8) ? ~shreg[0] : 1'b0`. After 8 reads the wire reads pressed-level 0, matching an official pad (CPU sees 1).
- `shift_count = count`.

## Timing
- Reset values: sync=0, deb=0, cnt=0, turbo counter=0, phase=0, shreg=0, count=0, pulse_q=0. Resulting outputs: `ctlr_data=1`, `btn_state=0`, `shift_count=0`.
- Raw to `btn_state` latency: 2 (sync) + DEBOUNCE_CYCLES cycles, for a raw change held throughout.
- Latch to data: `shreg` loads on the first clock edge with latch high. `ctlr_data` reflects A one cycle after latch first seen high.
- Pulse to next bit: `ctlr_data` changes one cycle after the cycle in which `ctlr_pulse` is seen low following high.
- Latch high and a pulse falling edge in the same cycle: latch wins (reload, no shift, count=0).
- Pulse while latch high: ignored. `ctlr_data` continuously tracks `~btn_state[0]`.
- `btn_state` changing while latch is low does not affect `shreg` until the next latch.
- Reset mid-shift: all state clears on that edge, so `ctlr_data=1` and `shift_count=0` the next cycle.
- Pulse edges beyond 8: `count` stays 8, `ctlr_data` stays 0.
- Turbo enable toggled mid-press: takes effect the same cycle (combinational gating).

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, TURBO_HALF=8.
- Reset: assert `reset` 2 cycles with `btn_raw=8'hFF` → `ctlr_data=1`, `btn_state=00`, `shift_count=0` while reset is held.
- Read sequence: hold `btn_raw=8'h09` → `btn_state=09` exactly 6 cycles later. Then apply latch high 1 cycle, then 8 read pulses (2 cycles high, 4 low) → `ctlr_data` during the reads is 0,1,1,0,1,1,1,1. A 9th and 10th read return 0, with `shift_count=8`.
- Debounce: raw bit1 high for 3 cycles then low → `btn_state` stays 00. Raw bit1 high for 6 cycles → `btn_state=02`.
- Opposing filter: `btn_raw=8'h30` → `btn_state=00`. Same stimulus with BLOCK_OPPOSING=0 → `btn_state=30`. `btn_raw=8'hC1` → `btn_state=01`.
- Turbo: `turbo_en=01`, A held → `btn_state[0]` is 0 for 8 cycles, then 1 for 8 cycles, repeating. Latching at each phase gives first read `ctlr_data` of 1 or 0 accordingly.
- Edge cases:
  - Pulses while latch is high → `shift_count` stays 0 and `ctlr_data` tracks `~btn_state[0]`.
  - Latch rising in the same cycle as a pulse falling edge → reload, `shift_count=0`.
  - Reset after 3 shifts → `shift_count=0`, `ctlr_data=1`.

Source files
------------

// File: rtl/nes_joypad.sv
// NES controller responder: synchronizes and debounces raw buttons, applies turbo
// and opposing-direction filtering, and shifts the latched state out per read pulse.
module nes_joypad #(
  parameter int DEBOUNCE_CYCLES = 21477,
  parameter int TURBO_HALF      = 715909,
  parameter bit BLOCK_OPPOSING  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] btn_raw,
  input  logic [1:0] turbo_en,
  input  logic       ctlr_latch,
  input  logic       ctlr_pulse,
  output logic       ctlr_data,
  output logic [7:0] btn_state,
  output logic [3:0] shift_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TRB_W = (TURBO_HALF > 1) ? $clog2(TURBO_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TRB_W-1:0] TRB_LAST = TRB_W'(TURBO_HALF - 1);

  logic [7:0]       sync1_r;
  logic [7:0]       sync_r;
  logic [7:0]       deb_r;
  logic [CNT_W-1:0] cnt_r [8];
  logic [7:0]       deb_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s [8];
  logic [TRB_W-1:0] tcnt_r;
  logic             phase_r;
  logic [7:0]       rep_s;
  logic [7:0]       shreg_r;
  logic [3:0]       count_r;
  logic             pulse_q_r;
  logic             pulse_fall_s;

  // Two-flop synchronizer for the asynchronous board buttons
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= 8'h00;
      sync_r  <= 8'h00;
    end else begin
      sync1_r <= btn_raw;
      sync_r  <= sync1_r;
    end
  end

  // Per-bit debounce: accept a change only after it has differed for DEBOUNCE_CYCLES edges
  always_comb begin
    deb_nxt_s = deb_r;
    for (int i = 0; i < 8; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (sync_r[i] == deb_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == CNT_LAST) begin
        deb_nxt_s[i] = sync_r[i];
        cnt_nxt_s[i] = '0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + 1'b1;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_r <= 8'h00;
      for (int i = 0; i < 8; i++) cnt_r[i] <= '0;
    end else begin
      deb_r <= deb_nxt_s;
      for (int i = 0; i < 8; i++) cnt_r[i] <= cnt_nxt_s[i];
    end
  end

  // Free-running turbo timebase; phase flips every TURBO_HALF cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt_r  <= '0;
      phase_r <= 1'b0;
    end else if (tcnt_r == TRB_LAST) begin
      tcnt_r  <= '0;
      phase_r <= ~phase_r;
    end else begin
      tcnt_r  <= tcnt_r + 1'b1;
      phase_r <= phase_r;
    end
  end

  // Reported buttons: turbo gating on A/B, opposing directions cancel each other
  always_comb begin
    rep_s    = deb_r;
    rep_s[0] = deb_r[0] & (turbo_en[0] ? phase_r : 1'b1);
    rep_s[1] = deb_r[1] & (turbo_en[1] ? phase_r : 1'b1);
    if (BLOCK_OPPOSING) begin
      if (deb_r[4] & deb_r[5]) rep_s[5:4] = 2'b00;
      else                     rep_s[5:4] = deb_r[5:4];
      if (deb_r[6] & deb_r[7]) rep_s[7:6] = 2'b00;
      else                     rep_s[7:6] = deb_r[7:6];
    end else begin
      rep_s[7:4] = deb_r[7:4];
    end
  end

  assign pulse_fall_s = pulse_q_r & ~ctlr_pulse;

  // Serial shifter: latch reloads every cycle it is high; shift on read-pulse falling edge
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_r   <= 8'h00;
      count_r   <= 4'd0;
      pulse_q_r <= 1'b0;
    end else begin
      pulse_q_r <= ctlr_pulse;
      if (ctlr_latch) begin
        shreg_r <= rep_s;
        count_r <= 4'd0;
      end else if (pulse_fall_s) begin
        shreg_r <= {1'b0, shreg_r[7:1]};
        count_r <= (count_r < 4'd8) ? count_r + 4'd1 : 4'd8;
      end else begin
        shreg_r <= shreg_r;
        count_r <= count_r;
      end
    end
  end

  // Past the eighth read the line sits at the pressed level, like an official pad
  assign ctlr_data   = (count_r < 4'd8) ? ~shreg_r[0] : 1'b0;
  assign btn_state   = rep_s;
  assign shift_count = count_r;

endmodule

// File: tb/tb_nes_joypad.sv
// Bench for nes_joypad: directed protocol scenarios plus random traffic checked
// against a cycle-level behavioural model of the controller.
module tb_nes_joypad;
  localparam int D = 4;
  localparam int T = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] btn_raw;
  logic [1:0] turbo_en;
  logic       ctlr_latch;
  logic       ctlr_pulse;
  logic       ctlr_data, ctlr_data2;
  logic [7:0] btn_state, btn_state2;
  logic [3:0] shift_count, shift_count2;

  int total = 0;
  int bad = 0;

  // model state
  logic [7:0] shist [D];
  logic [7:0] rh1_m, rh2_m, deb_m, snap_m, snap2_m;
  logic       prev_pulse_m;
  int         n_m, reads_m;

  nes_joypad #(.DEBOUNCE_CYCLES(D), .TURBO_HALF(T), .BLOCK_OPPOSING(1'b1)) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .turbo_en(turbo_en),
    .ctlr_latch(ctlr_latch), .ctlr_pulse(ctlr_pulse), .ctlr_data(ctlr_data),
    .btn_state(btn_state), .shift_count(shift_count));

  nes_joypad #(.DEBOUNCE_CYCLES(D), .TURBO_HALF(T), .BLOCK_OPPOSING(1'b0)) dut2 (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .turbo_en(turbo_en),
    .ctlr_latch(ctlr_latch), .ctlr_pulse(ctlr_pulse), .ctlr_data(ctlr_data2),
    .btn_state(btn_state2), .shift_count(shift_count2));

  always #5 clock = ~clock;

  function automatic logic [7:0] report(input logic [7:0] deb, input int n,
                                        input logic [1:0] ten, input bit block);
    logic [7:0] r;
    bit ph;
    r  = deb;
    ph = ((n / T) % 2) == 1;
    if (ten[0] && !ph) r[0] = 1'b0;
    if (ten[1] && !ph) r[1] = 1'b0;
    if (block && deb[4] && deb[5]) r[5:4] = 2'b00;
    if (block && deb[6] && deb[7]) r[7:6] = 2'b00;
    return r;
  endfunction

  function automatic logic exp_line(input logic [7:0] snap, input int reads);
    if (reads < 8) return ~snap[reads];
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    logic [7:0] nd;
    int ones;
    if (reset) begin
      for (int k = 0; k < D; k++) shist[k] = 8'h00;
      rh1_m = 8'h00; rh2_m = 8'h00; deb_m = 8'h00;
      snap_m = 8'h00; snap2_m = 8'h00;
      prev_pulse_m = 1'b0; n_m = 0; reads_m = 0;
    end else begin
      for (int k = D - 1; k > 0; k--) shist[k] = shist[k-1];
      shist[0] = rh2_m;
      nd = deb_m;
      for (int i = 0; i < 8; i++) begin
        ones = 0;
        for (int k = 0; k < D; k++) ones += int'(shist[k][i]);
        if (ones == D) nd[i] = 1'b1;
        else if (ones == 0) nd[i] = 1'b0;
      end
      if (ctlr_latch) begin
        snap_m  = report(deb_m, n_m, turbo_en, 1'b1);
        snap2_m = report(deb_m, n_m, turbo_en, 1'b0);
        reads_m = 0;
      end else if (prev_pulse_m && !ctlr_pulse) begin
        reads_m = (reads_m < 8) ? reads_m + 1 : 8;
      end
      prev_pulse_m = ctlr_pulse;
      rh2_m = rh1_m;
      rh1_m = btn_raw;
      deb_m = nd;
      n_m++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check("ctlr_data", {7'd0, ctlr_data}, {7'd0, exp_line(snap_m, reads_m)});
    check("btn_state", btn_state, report(deb_m, n_m, turbo_en, 1'b1));
    check("shift_count", {4'd0, shift_count}, 8'(reads_m));
    check("ctlr_data_nb", {7'd0, ctlr_data2}, {7'd0, exp_line(snap2_m, reads_m)});
    check("btn_state_nb", btn_state2, report(deb_m, n_m, turbo_en, 1'b0));
    check("shift_count_nb", {4'd0, shift_count2}, 8'(reads_m));
  endtask

  task automatic read_pulse(output logic data_seen);
    ctlr_pulse = 1'b1;
    tick();
    tick();
    data_seen = ctlr_data;
    ctlr_pulse = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int ones;
    logic d;
    logic [7:0] exp_seq;

    reset = 1'b1; btn_raw = 8'hFF; turbo_en = 2'b00;
    ctlr_latch = 1'b0; ctlr_pulse = 1'b0;

    // reset held with all buttons pressed
    tick();
    tick();
    check("rst_data", {7'd0, ctlr_data}, 8'h01);
    check("rst_btn", btn_state, 8'h00);
    check("rst_count", {4'd0, shift_count}, 8'h00);

    // read sequence with A+Start held
    btn_raw = 8'h09;
    reset = 1'b0;
    repeat (5) tick();
    check("deb_lat5", btn_state, 8'h00);
    tick();
    check("deb_lat6", btn_state, 8'h09);
    ctlr_latch = 1'b1;
    tick();
    ctlr_latch = 1'b0;
    exp_seq = 8'b1111_0110;
    for (int b = 0; b < 8; b++) begin
      read_pulse(d);
      check("read_bit", {7'd0, d}, {7'd0, exp_seq[b]});
    end
    for (int b = 0; b < 2; b++) begin
      read_pulse(d);
      check("read_extra", {7'd0, d}, 8'h00);
      check("count_sat", {4'd0, shift_count}, 8'h08);
    end

    // debounce glitch rejection then acceptance
    btn_raw = 8'h00;
    repeat (8) tick();
    btn_raw = 8'h02;
    repeat (3) tick();
    btn_raw = 8'h00;
    repeat (8) tick();
    check("glitch", btn_state, 8'h00);
    btn_raw = 8'h02;
    repeat (6) tick();
    check("deb_accept", btn_state, 8'h02);

    // opposing-direction filter
    btn_raw = 8'h30;
    repeat (8) tick();
    check("opp_ud", btn_state, 8'h00);
    check("opp_ud_nb", btn_state2, 8'h30);
    btn_raw = 8'hC1;
    repeat (8) tick();
    check("opp_lr", btn_state, 8'h01);
    check("opp_lr_nb", btn_state2, 8'hC1);

    // turbo on A: half duty over a whole number of periods, latching at both phases
    reset = 1'b1;
    btn_raw = 8'h01;
    tick();
    reset = 1'b0;
    turbo_en = 2'b01;
    repeat (6) tick();
    ones = 0;
    for (int k = 0; k < 32; k++) begin
      ctlr_latch = (k % 4) == 0;
      tick();
      ones += int'(btn_state[0]);
    end
    ctlr_latch = 1'b0;
    check("turbo_duty", 8'(ones), 8'd16);

    // pulses while latch is high are ignored
    ctlr_latch = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ctlr_pulse = 1'b1; tick(); tick();
      ctlr_pulse = 1'b0; tick(); tick();
    end
    check("latch_hold_cnt", {4'd0, shift_count}, 8'h00);
    ctlr_latch = 1'b0;
    turbo_en = 2'b00;
    repeat (2) tick();

    // latch rising together with a pulse falling edge
    read_pulse(d);
    ctlr_pulse = 1'b1;
    tick();
    ctlr_pulse = 1'b0;
    ctlr_latch = 1'b1;
    tick();
    check("latch_vs_fall", {4'd0, shift_count}, 8'h00);
    ctlr_latch = 1'b0;
    tick();

    // reset after three shifts
    for (int k = 0; k < 3; k++) read_pulse(d);
    check("three_shifts", {4'd0, shift_count}, 8'h03);
    reset = 1'b1;
    tick();
    check("mid_rst_cnt", {4'd0, shift_count}, 8'h00);
    check("mid_rst_data", {7'd0, ctlr_data}, 8'h01);
    reset = 1'b0;

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) btn_raw = 8'($urandom());
      else if ($urandom_range(0, 7) == 0) btn_raw[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 63) == 0) turbo_en = 2'($urandom());
      ctlr_latch = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0) ctlr_pulse = ~ctlr_pulse;
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
